// File: rtl/atcu_cmd_seq.sv
// AT-command transmit sequencer: runs the modem init script, then reads and deletes
// each newly indicated SMS slot, streaming ASCII bytes over a valid/ready link.
module atcu_cmd_seq #(
  parameter int unsigned RSP_TIMEOUT = 200000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rsp_valid,
  input  logic [2:0] rsp_code,
  input  logic [7:0] rsp_msg_no,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       init_done,
  output logic       sms_done,
  output logic [7:0] sms_index,
  output logic       err
);

  localparam int TW = (RSP_TIMEOUT > 2) ? $clog2(RSP_TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(RSP_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_READY, S_ERR} state_t;

  state_t          r_state, w_state_nx;
  logic [2:0]      r_cmd;
  logic [3:0]      r_pos;
  logic [7:0]      r_idx;
  logic [TW-1:0]   r_tmo;
  logic [RW-1:0]   r_retry;
  logic            r_pend;
  logic [7:0]      r_pend_idx;
  logic            r_init_done, r_sms_done, r_err;
  logic [7:0]      r_sms_index;

  // Command text, right-aligned in a 96-bit vector; the CR follows the last char.
  logic [7:0]  w_d2, w_d1, w_d0;
  logic [23:0] w_digs;
  logic [3:0]  w_ndig, w_len, w_sh;
  logic [95:0] w_str;
  logic [7:0]  w_byte;
  logic        w_last;

  assign w_d2 = r_idx / 8'd100;
  assign w_d1 = (r_idx / 8'd10) % 8'd10;
  assign w_d0 = r_idx % 8'd10;

  always_comb begin
    w_ndig = 4'd1;
    w_digs = {16'd0, 8'h30 + w_d0};
    if (r_idx >= 8'd100) begin
      w_ndig = 4'd3;
      w_digs = {8'h30 + w_d2, 8'h30 + w_d1, 8'h30 + w_d0};
    end else if (r_idx >= 8'd10) begin
      w_ndig = 4'd2;
      w_digs = {8'd0, 8'h30 + w_d1, 8'h30 + w_d0};
    end
    case (r_cmd)
      3'd0: begin w_str = {80'd0, "AT"};        w_len = 4'd2;  end
      3'd1: begin w_str = {64'd0, "ATE0"};      w_len = 4'd4;  end
      3'd2: begin w_str = {24'd0, "AT+CMGF=1"}; w_len = 4'd9;  end
      3'd3: begin w_str = "AT+CPMS=\"SM\"";     w_len = 4'd12; end
      3'd4: begin
        w_str = ({32'd0, "AT+CMGR="} << {w_ndig, 3'b000}) | {72'd0, w_digs};
        w_len = 4'd8 + w_ndig;
      end
      default: begin
        w_str = ({32'd0, "AT+CMGD="} << {w_ndig, 3'b000}) | {72'd0, w_digs};
        w_len = 4'd8 + w_ndig;
      end
    endcase
  end

  assign w_sh   = w_len - r_pos - 4'd1;
  assign w_last = (r_pos == w_len);
  assign w_byte = w_last ? 8'h0D : 8'(w_str >> {w_sh, 3'b000});

  logic w_xfer, w_ok, w_fail, w_ind, w_fin, w_can_retry;
  assign w_xfer      = (r_state == S_SEND) && tx_ready;
  assign w_ok        = rsp_valid && (rsp_code == 3'd1);
  // OK takes priority over a coinciding timeout via the if/else ordering below.
  assign w_fail      = (rsp_valid && (rsp_code == 3'd3)) || (r_tmo == TMO_LAST);
  assign w_ind       = rsp_valid && (rsp_code == 3'd4) && (rsp_msg_no != 8'd0);
  assign w_fin       = (r_cmd == 3'd3) || (r_cmd == 3'd5);
  assign w_can_retry = (r_retry < RETRY_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_ERR: if (start) w_state_nx = S_SEND;
      S_SEND:        if (w_xfer && w_last) w_state_nx = S_WAIT;
      S_WAIT: begin
        if (w_ok)        w_state_nx = (w_fin && !r_pend) ? S_READY : S_SEND;
        else if (w_fail) w_state_nx = w_can_retry ? S_SEND : S_ERR;
      end
      S_READY:       if (w_ind) w_state_nx = S_SEND;
      default:       w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd       <= 3'd0;
      r_pos       <= 4'd0;
      r_idx       <= 8'd0;
      r_tmo       <= '0;
      r_retry     <= '0;
      r_pend      <= 1'b0;
      r_pend_idx  <= 8'd0;
      r_init_done <= 1'b0;
      r_sms_done  <= 1'b0;
      r_sms_index <= 8'd0;
      r_err       <= 1'b0;
    end else begin
      r_sms_done <= 1'b0;
      if ((r_state == S_SEND || r_state == S_WAIT) && w_ind) begin
        r_pend     <= 1'b1;
        r_pend_idx <= rsp_msg_no;
      end
      case (r_state)
        S_IDLE, S_ERR: if (start) begin
          r_err       <= 1'b0;
          r_init_done <= 1'b0;
          r_retry     <= '0;
          r_cmd       <= 3'd0;
          r_pos       <= 4'd0;
          r_pend      <= 1'b0;
        end
        S_SEND: begin
          r_tmo <= '0;
          if (w_xfer) r_pos <= w_last ? 4'd0 : r_pos + 4'd1;
        end
        S_WAIT: begin
          r_tmo <= r_tmo + TW'(1);
          if (w_ok) begin
            r_retry <= '0;
            case (r_cmd)
              3'd0, 3'd1, 3'd2: r_cmd <= r_cmd + 3'd1;
              3'd3:             r_init_done <= 1'b1;
              3'd4:             r_cmd <= 3'd5;
              default: begin
                r_sms_done  <= 1'b1;
                r_sms_index <= r_idx;
              end
            endcase
            // A stored indication skips READY and goes straight to the read command.
            if (w_fin && r_pend) begin
              r_cmd  <= 3'd4;
              r_idx  <= r_pend_idx;
              r_pend <= 1'b0;
            end
          end else if (w_fail) begin
            if (w_can_retry) r_retry <= r_retry + RW'(1);
            else begin
              r_err  <= 1'b1;
              r_pend <= 1'b0;
            end
          end
        end
        S_READY: if (w_ind) begin
          r_cmd <= 3'd4;
          r_idx <= rsp_msg_no;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_valid  = (r_state == S_SEND);
    tx_data   = (r_state == S_SEND) ? w_byte : 8'h00;
    busy      = (r_state == S_SEND) || (r_state == S_WAIT);
    init_done = r_init_done;
    sms_done  = r_sms_done;
    sms_index = r_sms_index;
    err       = r_err;
  end

endmodule

// File: tb/tb_atcu_cmd_seq.sv
// Scoreboard bench for atcu_cmd_seq: expected bytes/indices are queued from the command
// text model; monitors pop and compare as the DUT transfers bytes or pulses sms_done.
module tb_atcu_cmd_seq;
  localparam int TMO = 50;
  localparam int MR  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rsp_valid = 1'b0;
  logic [2:0] rsp_code = 3'd0;
  logic [7:0] rsp_msg_no = 8'd0;
  logic       tx_ready = 1'b0;
  logic       tx_valid, busy, init_done, sms_done, err;
  logic [7:0] tx_data, sms_index;

  always #5 clk = ~clk;

  atcu_cmd_seq #(.RSP_TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .start(start), .rsp_valid(rsp_valid), .rsp_code(rsp_code),
    .rsp_msg_no(rsp_msg_no), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .busy(busy), .init_done(init_done), .sms_done(sms_done), .sms_index(sms_index), .err(err)
  );

  int n_tests = 0, n_fail = 0;
  int cr_cnt = 0, crs_seen = 0;
  int rdy_mode = 0;
  logic [7:0] exp_q[$];
  int         sms_q[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endfunction

  function automatic string cmd_body(input int c, input int n);
    case (c)
      0: return "AT";
      1: return "ATE0";
      2: return "AT+CMGF=1";
      3: return "AT+CPMS=\"SM\"";
      4: return $sformatf("AT+CMGR=%0d", n);
      default: return $sformatf("AT+CMGD=%0d", n);
    endcase
  endfunction

  task automatic push_cmd(input int c, input int n);
    string s;
    s = cmd_body(c, n);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
  endtask

  // tx_ready pattern: 0 always, 1 toggle, 2 random, other = driven by the main process
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ~tx_ready;
      2: tx_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  logic       prev_hold = 1'b0, prev_sms = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] e_byte;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      prev_sms  = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_byte: unexpected byte %0h, none expected", tx_data);
        end else begin
          e_byte = exp_q.pop_front();
          chk("tx_byte", tx_data, e_byte);
        end
        if (tx_data == 8'h0D) cr_cnt++;
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (sms_done) begin
        chk("sms_done_width", prev_sms, 0);
        if (sms_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sms_done: unexpected pulse, index %0d", sms_index);
        end else chk("sms_index_at_pulse", sms_index, sms_q.pop_front());
      end
      prev_sms = sms_done;
    end
  end

  task automatic wait_cr();
    int k;
    k = 0;
    while (cr_cnt <= crs_seen && k < 400) begin
      @(posedge clk);
      k++;
    end
    chk("cr_timeout", 32'(cr_cnt > crs_seen), 1);
    crs_seen++;
  endtask

  task automatic pulse_rsp(input logic [2:0] c, input logic [7:0] m);
    @(posedge clk); #1;
    rsp_valid = 1'b1; rsp_code = c; rsp_msg_no = m;
    @(posedge clk); #1;
    rsp_valid = 1'b0; rsp_code = 3'd0;
  endtask

  task automatic reply(input logic [2:0] c, input int dly);
    wait_cr();
    repeat (dly) @(posedge clk);
    pulse_rsp(c, 8'($urandom));
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    crs_seen = cr_cnt;
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_sms_done"}, sms_done, 0);
    chk({tag, "_sms_index"}, sms_index, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic settle_check(input string tag, input logic want_init);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({tag, "_init_done"}, init_done, 32'(want_init));
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  int idxs[6];
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rst("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Init script, OK 10 cycles after each CR, toggling ready during C2
    rdy_mode = 0;
    for (int c = 0; c < 4; c++) push_cmd(c, 0);
    do_start();
    reply(3'd1, 10);
    wait_cr(); rdy_mode = 1;
    repeat (10) @(posedge clk);
    pulse_rsp(3'd1, 8'd0);
    wait_cr(); rdy_mode = 0;
    repeat (10) @(posedge clk);
    pulse_rsp(3'd1, 8'd0);
    reply(3'd1, 10);
    settle_check("init", 1'b1);

    // SMS service under random backpressure, digit-count corners then random indices
    rdy_mode = 2;
    idxs = '{42, 7, 100, 255, 0, 0};
    for (int i = 4; i < 6; i++) idxs[i] = $urandom_range(1, 255);
    for (int i = 0; i < 6; i++) begin
      push_cmd(4, idxs[i]);
      push_cmd(5, idxs[i]);
      sms_q.push_back(idxs[i]);
      pulse_rsp(3'd4, 8'(idxs[i]));
      if (i == 1) do_start();
      if (i % 2 == 1) begin
        wait_cr();
        pulse_rsp(3'd2, 8'd9);
        pulse_rsp(3'd1, 8'd0);
      end else reply(3'd1, $urandom_range(0, 20));
      reply(3'd1, $urandom_range(0, 20));
      settle_check("sms", 1'b1);
      chk("sms_index_held", sms_index, idxs[i]);
    end
    pulse_rsp(3'd4, 8'd0);
    pulse_rsp(3'd2, 8'd9);
    pulse_rsp(3'd5, 8'd3);
    pulse_rsp(3'd3, 8'd0);
    do_start();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("ready_ignore_tx_valid", tx_valid, 0);
    settle_check("ready_ignore", 1'b1);

    // Pending indications during init: last index wins, C4 issued without idling
    do_reset();
    @(negedge clk);
    check_rst("reset2");
    for (int c = 0; c < 4; c++) push_cmd(c, 0);
    push_cmd(4, 255); push_cmd(5, 255); sms_q.push_back(255);
    do_start();
    reply(3'd1, $urandom_range(0, 20));
    pulse_rsp(3'd4, 8'd7);
    reply(3'd1, $urandom_range(0, 20));
    pulse_rsp(3'd4, 8'd255);
    reply(3'd1, $urandom_range(0, 20));
    reply(3'd1, $urandom_range(0, 20));
    @(negedge clk);
    chk("pend_tx_valid", tx_valid, 1);
    chk("pend_busy", busy, 1);
    chk("pend_init_done", init_done, 1);
    reply(3'd1, $urandom_range(0, 20));
    reply(3'd1, $urandom_range(0, 20));
    settle_check("pend", 1'b1);
    chk("pend_sms_index", sms_index, 255);

    // ERROR twice on C1 then OK: three sends of ATE0
    do_reset();
    push_cmd(0, 0);
    for (int k = 0; k < 3; k++) push_cmd(1, 0);
    push_cmd(2, 0); push_cmd(3, 0);
    do_start();
    reply(3'd1, $urandom_range(0, 20));
    reply(3'd3, $urandom_range(0, 20));
    reply(3'd3, $urandom_range(0, 20));
    for (int k = 0; k < 3; k++) reply(3'd1, $urandom_range(0, 20));
    settle_check("retry", 1'b1);
    chk("retry_err", err, 0);

    // No replies: AT sent 1+MAX_RETRY times, then ERR
    do_reset();
    for (int k = 0; k <= MR; k++) push_cmd(0, 0);
    do_start();
    for (int k = 0; k < 600 && !err; k++) @(posedge clk);
    @(negedge clk);
    chk("tmo_err", err, 1);
    chk("tmo_tx_valid", tx_valid, 0);
    repeat (TMO + 10) @(posedge clk);
    settle_check("tmo", 1'b0);
    chk("tmo_err_sticky", err, 1);
    crs_seen = cr_cnt;

    // Restart from ERR, then async reset while C3 is stalled mid-command
    push_cmd(0, 0); push_cmd(1, 0); push_cmd(2, 0);
    exp_q.push_back("A"); exp_q.push_back("T"); exp_q.push_back("+"); exp_q.push_back("C");
    do_start();
    @(negedge clk);
    chk("restart_err_clr", err, 0);
    chk("restart_busy", busy, 1);
    reply(3'd1, $urandom_range(0, 20));
    reply(3'd1, $urandom_range(0, 20));
    wait_cr();
    #2 rdy_mode = 4; tx_ready = 1'b0;
    pulse_rsp(3'd1, 8'd0);
    @(posedge clk); #2 tx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2 tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("stall_tx_valid", tx_valid, 1);
    chk("stall_tx_data", tx_data, 8'h50);
    #2 rst = 1'b1;
    #1 check_rst("async_rst");
    chk("async_q_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    crs_seen = cr_cnt;
    rdy_mode = 2;

    for (int c = 0; c < 4; c++) push_cmd(c, 0);
    do_start();
    for (int k = 0; k < 4; k++) reply(3'd1, $urandom_range(0, 20));
    settle_check("post_rst", 1'b1);
    chk("sms_q_empty", sms_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
